// File: rtl/r16_dtfag_pkg.sv
// rtl/r16_dtfag_pkg.sv - shared constants for the radix-16 twiddle-factor generator
package r16_dtfag_pkg;

  localparam int DW     = 64;
  localparam int MM_LAT = 3;
  localparam int TF_LAT = 7;

  // Goldilocks prime 2^64 - 2^32 + 1 and its Barrett constant floor(2^128 / P).
  localparam logic [DW-1:0] P  = 64'hFFFF_FFFF_0000_0001;
  localparam logic [DW:0]   MU = 65'h1_0000_0000_FFFF_FFFF;

  localparam logic [1:0] TBL_J = 2'd0;
  localparam logic [1:0] TBL_T = 2'd1;
  localparam logic [1:0] TBL_I = 2'd2;

  localparam logic [1:0] STAGE_FINAL = 2'd3;

endpackage

// File: rtl/r16_mod_mul.sv
// rtl/r16_mod_mul.sv - three-cycle Barrett modular multiplier with valid and force-one sideband
module r16_mod_mul
  import r16_dtfag_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          force_one,
  output logic [DW-1:0] res,
  output logic          out_valid
);

  localparam int XW = 2 * DW;
  localparam int QW = DW + 1;
  localparam int RW = DW + 2;
  localparam logic [RW-1:0] P_X = {2'b00, P};

  logic [XW-1:0] x_q;
  logic [RW-1:0] r_q;
  logic          v1, v2, f1, f2;

  logic [QW-1:0] qv;
  logic [RW-1:0] r_c, r1, r2;

  // Barrett quotient estimate (at most 2 short) and the two conditional subtractions.
  always_comb begin
    qv  = QW'(({{QW{1'b0}}, x_q[XW-1:DW-1]} * {{QW{1'b0}}, MU}) >> QW);
    r_c = x_q[RW-1:0] - RW'({1'b0, qv} * P_X);
    r1  = (r_q >= P_X) ? r_q - P_X : r_q;
    r2  = (r1 >= P_X) ? r1 - P_X : r1;
  end

  // Registers 1 and 2: full product, then partially reduced remainder in [0, 3P).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      r_q <= '0;
      v1  <= 1'b0;
      v2  <= 1'b0;
      f1  <= 1'b0;
      f2  <= 1'b0;
    end else begin
      x_q <= XW'(a) * XW'(b);
      r_q <= r_c;
      v1  <= in_valid;
      v2  <= v1;
      f1  <= force_one;
      f2  <= f1;
    end
  end

  // Register 3: final result, loaded only for valid items so the output holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v2;
      if (v2) res <= f2 ? DW'(1) : DW'(r2);
    end
  end

endmodule

// File: rtl/r16_dtfag_tf_gen.sv
// rtl/r16_dtfag_tf_gen.sv - twiddle factor Tj*Tt*Ti mod P per cycle, 7-cycle latency; R16_DTFAG_INV_EN adds inverse tables
module r16_dtfag_tf_gen
  import r16_dtfag_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [3:0]    dtfag_j,
  input  logic [3:0]    dtfag_t,
  input  logic [3:0]    dtfag_i,
  input  logic [1:0]    fft_stage,
  input  logic          tf_wr_en,
  input  logic [1:0]    tf_wr_tbl,
  input  logic [1:0]    tf_wr_stage,
  input  logic [3:0]    tf_wr_addr,
  input  logic [DW-1:0] tf_wr_data,
`ifdef R16_DTFAG_INV_EN
  input  logic          inv_sel,
  input  logic          tf_wr_inv,
`endif
  output logic [DW-1:0] tf_out,
  output logic          tf_valid
);

`ifdef R16_DTFAG_INV_EN
  localparam int AW = 7;
  logic [AW-1:0] rd_j, rd_t, rd_i, wr_a;
  assign rd_j = {inv_sel, fft_stage, dtfag_j};
  assign rd_t = {inv_sel, fft_stage, dtfag_t};
  assign rd_i = {inv_sel, fft_stage, dtfag_i};
  assign wr_a = {tf_wr_inv, tf_wr_stage, tf_wr_addr};
`else
  localparam int AW = 6;
  logic [AW-1:0] rd_j, rd_t, rd_i, wr_a;
  assign rd_j = {fft_stage, dtfag_j};
  assign rd_t = {fft_stage, dtfag_t};
  assign rd_i = {fft_stage, dtfag_i};
  assign wr_a = {tf_wr_stage, tf_wr_addr};
`endif

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] tj_mem [DEPTH];
  logic [DW-1:0] tt_mem [DEPTH];
  logic [DW-1:0] ti_mem [DEPTH];

  logic [DW-1:0] tj_r, tt_r, ti_r;
  logic [1:0]    st_r;
  logic          v_r;

  logic [DW-1:0] ti_d [MM_LAT];
  logic [1:0]    st_d [MM_LAT];

  logic [DW-1:0] prod_a;
  logic          v_a;

  // Table write port; tables carry no reset, and code 3 writes nothing.
  always_ff @(posedge clk) begin
    if (tf_wr_en) begin
      case (tf_wr_tbl)
        TBL_J:   tj_mem[wr_a] <= tf_wr_data;
        TBL_T:   tt_mem[wr_a] <= tf_wr_data;
        TBL_I:   ti_mem[wr_a] <= tf_wr_data;
        default: ;
      endcase
    end
  end

  // Read stage R1: a same-cycle write to the read entry is seen only from the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tj_r <= '0;
      tt_r <= '0;
      ti_r <= '0;
      st_r <= '0;
      v_r  <= 1'b0;
    end else begin
      tj_r <= tj_mem[rd_j];
      tt_r <= tt_mem[rd_t];
      ti_r <= ti_mem[rd_i];
      st_r <= fft_stage;
      v_r  <= in_valid;
    end
  end

  // Carry Ti and stage alongside the first multiplier so they meet its result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MM_LAT; k++) begin
        ti_d[k] <= '0;
        st_d[k] <= '0;
      end
    end else begin
      ti_d[0] <= ti_r;
      st_d[0] <= st_r;
      for (int k = 1; k < MM_LAT; k++) begin
        ti_d[k] <= ti_d[k-1];
        st_d[k] <= st_d[k-1];
      end
    end
  end

  r16_mod_mul u_mul_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v_r),
    .a         (tj_r),
    .b         (tt_r),
    .force_one (1'b0),
    .res       (prod_a),
    .out_valid (v_a)
  );

  // Register 3 of this multiplier is the output register; the final-stage override lands there.
  r16_mod_mul u_mul_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v_a),
    .a         (prod_a),
    .b         (ti_d[MM_LAT-1]),
    .force_one (st_d[MM_LAT-1] == STAGE_FINAL),
    .res       (tf_out),
    .out_valid (tf_valid)
  );

endmodule
